// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. A single (N+1)-bit ripple-carry
//   subtractor produces one quotient bit per cycle. Operands arrive through a
//   valid/ready handshake and results leave through another one. The FSM owns
//   the operand muxing, the shift registers and the iteration counter.
//
//   Optional feature (macro DIV_ZERO_DETECT_EN):
//     defined   - a zero divisor skips the iterations, goes straight to DONE
//                 and raises div_err alongside quotient=all-ones,
//                 remainder=dividend.
//     undefined - a zero divisor runs the normal iterations (the natural
//                 result is the same quotient/remainder); div_err is tied 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands presented
//   in_ready   out  block can accept operands (high only in IDLE)
//   dividend   in   [N-1:0] numerator, sampled on in_valid & in_ready
//   divisor    in   [N-1:0] denominator, sampled on in_valid & in_ready
//   out_valid  out  quotient/remainder valid (registered)
//   out_ready  in   consumer accepts the result
//   quotient   out  [N-1:0] floor(dividend/divisor)
//   remainder  out  [N-1:0] dividend mod divisor
//   div_err    out  divide-by-zero flag
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     d_reg;
  logic [N-1:0]     p_reg;

  logic [N:0]       s_val;
  logic [N:0]       sub_res;
  logic             cout;
  logic [N-1:0]     q_nxt;
  logic [N-1:0]     p_nxt;

  // Ripple-carry a - b over N+1 bits. Returns {carry_out, diff[N-1:0]}; the
  // top difference bit is not needed because a successful subtraction always
  // leaves a result below the divisor, which fits in N bits.
  function automatic logic [N:0] rc_sub(input logic [N:0] a, input logic [N:0] b);
    logic       c;
    logic [N:0] d;
    c = 1'b1;
    for (int i = 0; i <= N; i++) begin
      d[i] = a[i] ^ ~b[i] ^ c;
      c    = (a[i] & ~b[i]) | (a[i] & c) | (~b[i] & c);
    end
    return {c, d[N-1:0]};
  endfunction

  assign in_ready = (state == S_IDLE);

  // One restoring iteration: shift in the next dividend bit, try to subtract.
  always_comb begin
    s_val   = {p_reg, q_reg[N-1]};
    sub_res = rc_sub(s_val, {1'b0, d_reg});
    cout    = sub_res[N];
    q_nxt   = {q_reg[N-2:0], cout};
    p_nxt   = cout ? sub_res[N-1:0] : s_val[N-1:0];
  end

  // Working registers: loaded on accept, shifted during CALC; contents are
  // don't-care outside an operation so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      q_reg <= dividend;
      d_reg <= divisor;
      p_reg <= '0;
    end else if (state == S_CALC) begin
      q_reg <= q_nxt;
      p_reg <= p_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_err   <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            quotient  <= q_nxt;
            remainder <= p_nxt;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // out_valid rises on the first DONE cycle, then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div_err   <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef DIV_ZERO_DETECT_EN
  assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Scoreboard bench for seq_restoring_divider (N=8). Expected results are
//   queued as operands are driven and compared when a result is handed over.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_err;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] dv;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic busy  = 1'b0;
  logic prev_ov = 1'b0;

  seq_restoring_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor and in_ready tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else                check("latency", cyc - acc_cyc, sb[0].lat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_err", div_err, e.err);
          if (e.dv != 0) check("rem_lt_div", remainder < e.dv, 1);
        end
      end
      if (in_valid && in_ready) begin
        busy    = 1'b1;
        acc_cyc = cyc + 1;
      end
      if (out_valid && out_ready) busy = 1'b0;
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("accept_timeout", 0, 1);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
`ifdef DIV_ZERO_DETECT_EN
      e.err = 1'b1;
      e.lat = 1;
`else
      e.err = 1'b0;
      e.lat = N + 1;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.err = 1'b0;
      e.lat = N + 1;
    end
    e.dv = b;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    check("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_err", div_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Basic operation, latency checked by the monitor.
    do_op(8'd100, 8'd7);
    wait_drain();

    // Back-to-back with the consumer always ready.
    do_op(8'd255, 8'd1);
    do_op(8'd5, 8'd9);
    wait_drain();

    // Edge cases.
    do_op(8'd0, 8'd37);
    do_op(8'd12, 8'd200);
    do_op(8'd255, 8'd255);
    do_op(8'd128, 8'd2);
    wait_drain();

    // Backpressure: result must hold for 20 cycles.
    out_ready = 1'b0;
    do_op(8'd200, 8'd13);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) check("bp_valid_timeout", 0, 1);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_quotient", quotient, 15);
      check("bp_remainder", remainder, 5);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", out_valid, 0);
    wait_drain();

    // Divide by zero.
    do_op(8'd42, 8'd0);
    wait_drain();

    // Asynchronous reset in the middle of a calculation.
    do_op(8'd170, 8'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_output", out_valid, 0);
    do_op(8'd9, 8'd3);
    wait_drain();

    // Random sweep.
    for (int i = 0; i < 2000; i++) begin
      do_op(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)));
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
